// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the writeback/MDU/decode signals that meet at the register-file write port.
// The arbiter sits on the slave side; the pipeline, MDU and decode drive the master side.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     pipe_valid;
    logic [ADDRESS_WIDTH-1:0] pipe_addr;
    logic [DATA_WIDTH-1:0]    pipe_data;
    logic                     mdu_valid;
    logic                     mdu_ready;
    logic [ADDRESS_WIDTH-1:0] mdu_addr;
    logic [DATA_WIDTH-1:0]    mdu_data;
    logic                     issue_valid;
    logic [ADDRESS_WIDTH-1:0] issue_addr;
    logic [ADDRESS_WIDTH-1:0] read_addr1;
    logic [ADDRESS_WIDTH-1:0] read_addr2;
    logic                     hazard1;
    logic                     hazard2;
    logic                     pipe_hold;
    logic                     write_en;
    logic [ADDRESS_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0]    write_data;

    modport slave (
        input  pipe_valid, pipe_addr, pipe_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  issue_valid, issue_addr, read_addr1, read_addr2,
        output mdu_ready, hazard1, hazard2, pipe_hold,
        output write_en, write_addr, write_data
    );

    modport master (
        output pipe_valid, pipe_addr, pipe_data,
        output mdu_valid, mdu_addr, mdu_data,
        output issue_valid, issue_addr, read_addr1, read_addr2,
        input  mdu_ready, hazard1, hazard2, pipe_hold,
        input  write_en, write_addr, write_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and the MDU,
// with a one-entry MDU overflow buffer, starvation hold and a busy scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
    localparam int CNT_W    = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] C_SAT   = CNT_W'(STARVE_LIMIT + 1);

    logic                     r_buf_valid;
    logic [ADDRESS_WIDTH-1:0] r_buf_addr;
    logic [DATA_WIDTH-1:0]    r_buf_data;
    logic [CNT_W-1:0]         r_starve_cnt;
    logic                     r_pipe_hold;
    logic [NUM_REGS-1:0]      r_busy;
    logic                     r_write_en;
    logic [ADDRESS_WIDTH-1:0] r_write_addr;
    logic [DATA_WIDTH-1:0]    r_write_data;

    logic                     w_mdu_ready;
    logic                     w_pipe_win;
    logic                     w_mdu_take;
    logic                     w_buf_drain;
    logic                     w_mdu_park;
    logic                     w_own_valid;
    logic                     w_mdu_retire;
    logic [ADDRESS_WIDTH-1:0] w_own_addr;
    logic [DATA_WIDTH-1:0]    w_own_data;
    logic [CNT_W-1:0]         w_starve_next;
    logic [NUM_REGS-1:0]      w_busy_next;

    assign w_mdu_ready = ~r_buf_valid;
    assign w_pipe_win  = bus.pipe_valid && (bus.pipe_addr != '0);
    // x0 results are swallowed here: accepted, but never park or reach the port
    assign w_mdu_take  = bus.mdu_valid && w_mdu_ready && (bus.mdu_addr != '0);
    assign w_buf_drain = r_buf_valid && !w_pipe_win;
    assign w_mdu_park  = w_mdu_take && w_pipe_win;

    always_comb begin
        w_own_valid  = 1'b0;
        w_mdu_retire = 1'b0;
        w_own_addr   = r_write_addr;
        w_own_data   = r_write_data;
        if (w_pipe_win) begin
            w_own_valid = 1'b1;
            w_own_addr  = bus.pipe_addr;
            w_own_data  = bus.pipe_data;
        end else if (r_buf_valid) begin
            w_own_valid  = 1'b1;
            w_mdu_retire = 1'b1;
            w_own_addr   = r_buf_addr;
            w_own_data   = r_buf_data;
        end else if (w_mdu_take) begin
            w_own_valid  = 1'b1;
            w_mdu_retire = 1'b1;
            w_own_addr   = bus.mdu_addr;
            w_own_data   = bus.mdu_data;
        end
    end

    // Saturates one past the limit so a misbehaving pipeline cannot re-trigger the hold
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (!r_buf_valid || w_buf_drain)
            w_starve_next = '0;
        else if (r_starve_cnt != C_SAT)
            w_starve_next = r_starve_cnt + 1'b1;
    end

    // Clear first, then set, so a same-edge issue to the retiring register keeps it busy
    always_comb begin
        w_busy_next = r_busy;
        if (w_mdu_retire)
            w_busy_next[w_own_addr] = 1'b0;
        if (bus.issue_valid && (bus.issue_addr != '0))
            w_busy_next[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid  <= 1'b0;
            r_buf_addr   <= '0;
            r_buf_data   <= '0;
            r_starve_cnt <= '0;
            r_pipe_hold  <= 1'b0;
            r_busy       <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            r_write_en   <= w_own_valid;
            r_write_addr <= w_own_addr;
            r_write_data <= w_own_data;
            if (w_mdu_park) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= bus.mdu_addr;
                r_buf_data  <= bus.mdu_data;
            end else if (w_buf_drain) begin
                r_buf_valid <= 1'b0;
            end
            r_starve_cnt <= w_starve_next;
            r_pipe_hold  <= (w_starve_next == C_LIMIT);
            r_busy       <= w_busy_next;
        end
    end

    assign bus.mdu_ready  = w_mdu_ready;
    assign bus.hazard1    = r_busy[bus.read_addr1];
    assign bus.hazard2    = r_busy[bus.read_addr2];
    assign bus.pipe_hold  = r_pipe_hold;
    assign bus.write_en   = r_write_en;
    assign bus.write_addr = r_write_addr;
    assign bus.write_data = r_write_data;

    a_no_pipe_during_hold: assert property (
        @(posedge clk) disable iff (rst) !(bus.pipe_valid && r_pipe_hold));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model
// of the write-port arbiter.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LIMIT = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pipe_valid  = 1'b0;
        bus.pipe_addr   = '0;
        bus.pipe_data   = '0;
        bus.mdu_valid   = 1'b0;
        bus.mdu_addr    = '0;
        bus.mdu_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_addr  = '0;
        bus.read_addr1  = '0;
        bus.read_addr2  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (bus.write_en !== 1'b0 || bus.write_addr !== '0 || bus.write_data !== '0) begin
            fails++;
            $display("FAIL reset_write: got en=%b addr=%0d data=%h, need 0/0/0",
                     bus.write_en, bus.write_addr, bus.write_data);
        end
        tests++;
        if (bus.mdu_ready !== 1'b1 || bus.pipe_hold !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got mdu_ready=%b pipe_hold=%b, need 1/0",
                     bus.mdu_ready, bus.pipe_hold);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_addr = 5;
        step();
        idle();
        bus.read_addr1 = 5;
        bus.pipe_valid = 1'b1; bus.pipe_addr = 1; bus.pipe_data = 32'h77;
        bus.mdu_valid  = 1'b1; bus.mdu_addr  = 5; bus.mdu_data  = 32'h11;
        step();
        bus.pipe_valid = 1'b0; bus.mdu_valid = 1'b0;
        #1;
        tests++;
        if (bus.mdu_ready !== 1'b0 || bus.hazard1 !== 1'b1 || bus.write_en !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre: got ready=%b hz=%b en=%b, need 0/1/1",
                     bus.mdu_ready, bus.hazard1, bus.write_en);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.write_en !== 1'b0 || bus.mdu_ready !== 1'b1 || bus.hazard1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: got en=%b ready=%b hz=%b, need 0/1/0",
                     bus.write_en, bus.mdu_ready, bus.hazard1);
        end
        rst = 1'b0;
        step();
        tests++;
        if (bus.write_en !== 1'b0 || bus.mdu_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_discard: got en=%b ready=%b, need 0/1",
                     bus.write_en, bus.mdu_ready);
        end
    endtask

    task automatic test_lone_pipe();
        do_reset();
        bus.pipe_valid = 1'b1; bus.pipe_addr = 3; bus.pipe_data = 32'hDEADBEEF;
        step();
        bus.pipe_valid = 1'b0;
        tests++;
        if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd3 || bus.write_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL lone_pipe: got en=%b addr=%0d data=%h, need 1/3/deadbeef",
                     bus.write_en, bus.write_addr, bus.write_data);
        end
        step();
        tests++;
        if (bus.write_en !== 1'b0 || bus.write_addr !== 5'd3 || bus.write_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL lone_pipe_after: got en=%b addr=%0d data=%h, need 0/3/deadbeef",
                     bus.write_en, bus.write_addr, bus.write_data);
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_addr = 7;
        step();
        idle();
        bus.read_addr2 = 7;
        bus.pipe_valid = 1'b1; bus.pipe_addr = 4; bus.pipe_data = 32'hA;
        bus.mdu_valid  = 1'b1; bus.mdu_addr  = 7; bus.mdu_data  = 32'hB;
        #1;
        tests++;
        if (bus.mdu_ready !== 1'b1 || bus.hazard2 !== 1'b1) begin
            fails++;
            $display("FAIL collision_pre: got ready=%b hz2=%b, need 1/1", bus.mdu_ready, bus.hazard2);
        end
        step();
        bus.pipe_valid = 1'b0; bus.mdu_valid = 1'b0;
        tests++;
        if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd4 || bus.write_data !== 32'hA ||
            bus.mdu_ready !== 1'b0 || bus.hazard2 !== 1'b1) begin
            fails++;
            $display("FAIL collision_edge1: got en=%b addr=%0d data=%h ready=%b hz2=%b, need 1/4/a/0/1",
                     bus.write_en, bus.write_addr, bus.write_data, bus.mdu_ready, bus.hazard2);
        end
        step();
        tests++;
        if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd7 || bus.write_data !== 32'hB ||
            bus.hazard2 !== 1'b0 || bus.mdu_ready !== 1'b1) begin
            fails++;
            $display("FAIL collision_edge2: got en=%b addr=%0d data=%h hz2=%b ready=%b, need 1/7/b/0/1",
                     bus.write_en, bus.write_addr, bus.write_data, bus.hazard2, bus.mdu_ready);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        bus.pipe_valid = 1'b1; bus.pipe_addr = 10; bus.pipe_data = 32'h0;
        bus.mdu_valid  = 1'b1; bus.mdu_addr  = 9;  bus.mdu_data  = 32'h55;
        step();
        bus.mdu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (bus.pipe_hold !== 1'b0) begin
                fails++;
                $display("FAIL starve_early_hold[%0d]: got %b, need 0", i, bus.pipe_hold);
            end
            bus.pipe_addr = AW'(i);
            bus.pipe_data = 32'h100 + i;
            step();
        end
        bus.pipe_valid = 1'b0;
        tests++;
        if (bus.pipe_hold !== 1'b1 || bus.write_addr !== 5'd4 || bus.mdu_ready !== 1'b0) begin
            fails++;
            $display("FAIL starve_hold: got hold=%b addr=%0d ready=%b, need 1/4/0",
                     bus.pipe_hold, bus.write_addr, bus.mdu_ready);
        end
        step();
        tests++;
        if (bus.pipe_hold !== 1'b0 || bus.write_en !== 1'b1 || bus.write_addr !== 5'd9 ||
            bus.write_data !== 32'h55) begin
            fails++;
            $display("FAIL starve_drain: got hold=%b en=%b addr=%0d data=%h, need 0/1/9/55",
                     bus.pipe_hold, bus.write_en, bus.write_addr, bus.write_data);
        end
        step();
        tests++;
        if (bus.pipe_hold !== 1'b0 || bus.write_en !== 1'b0 || bus.mdu_ready !== 1'b1) begin
            fails++;
            $display("FAIL starve_after: got hold=%b en=%b ready=%b, need 0/0/1",
                     bus.pipe_hold, bus.write_en, bus.mdu_ready);
        end
    endtask

    task automatic test_x0_discard();
        do_reset();
        bus.pipe_valid = 1'b1; bus.pipe_addr = 0; bus.pipe_data = 32'h1;
        bus.mdu_valid  = 1'b1; bus.mdu_addr  = 6; bus.mdu_data  = 32'h2;
        step();
        idle();
        tests++;
        if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd6 || bus.write_data !== 32'h2 ||
            bus.mdu_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_mdu_direct: got en=%b addr=%0d data=%h ready=%b, need 1/6/2/1",
                     bus.write_en, bus.write_addr, bus.write_data, bus.mdu_ready);
        end
        bus.mdu_valid = 1'b1; bus.mdu_addr = 0; bus.mdu_data = 32'h3;
        step();
        idle();
        tests++;
        if (bus.write_en !== 1'b0 || bus.mdu_ready !== 1'b1 || bus.write_addr !== 5'd6) begin
            fails++;
            $display("FAIL x0_mdu_only: got en=%b ready=%b addr=%0d, need 0/1/6",
                     bus.write_en, bus.mdu_ready, bus.write_addr);
        end
        bus.issue_valid = 1'b1; bus.issue_addr = 0;
        step();
        idle();
        tests++;
        if (bus.hazard1 !== 1'b0 || bus.hazard2 !== 1'b0) begin
            fails++;
            $display("FAIL x0_hazard: got hz1=%b hz2=%b, need 0/0", bus.hazard1, bus.hazard2);
        end
    endtask

    task automatic test_scoreboard_race();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_addr = 8;
        step();
        bus.read_addr1 = 8;
        bus.mdu_valid  = 1'b1; bus.mdu_addr = 8; bus.mdu_data = 32'hC0DE;
        step();
        bus.issue_valid = 1'b0; bus.mdu_valid = 1'b0;
        tests++;
        if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd8 || bus.hazard1 !== 1'b1) begin
            fails++;
            $display("FAIL race_set_wins: got en=%b addr=%0d hz1=%b, need 1/8/1",
                     bus.write_en, bus.write_addr, bus.hazard1);
        end
        bus.mdu_valid = 1'b1; bus.mdu_data = 32'hC0DF;
        step();
        bus.mdu_valid = 1'b0;
        tests++;
        if (bus.hazard1 !== 1'b0) begin
            fails++;
            $display("FAIL race_later_clear: got hz1=%b, need 0", bus.hazard1);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          from_mdu;
    } wr_t;

    task automatic test_random();
        wr_t           buffer[$];
        wr_t           cands[$];
        wr_t           win;
        bit            busy[32];
        int            waits;
        bit            hold;
        bit            exp_en;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        bit            had_buf;
        bit            buf_stayed;
        do_reset();
        foreach (busy[i]) busy[i] = 1'b0;
        waits = 0; hold = 1'b0; exp_en = 1'b0; exp_addr = '0; exp_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.pipe_valid  = !hold && ($urandom_range(0, 3) != 0);
            bus.pipe_addr   = AW'($urandom_range(0, 7));
            bus.pipe_data   = $urandom;
            bus.mdu_valid   = $urandom_range(0, 1) == 1;
            bus.mdu_addr    = AW'($urandom_range(0, 7));
            bus.mdu_data    = $urandom;
            bus.issue_valid = $urandom_range(0, 2) == 0;
            bus.issue_addr  = AW'($urandom_range(0, 7));
            bus.read_addr1  = AW'($urandom_range(0, 7));
            bus.read_addr2  = AW'($urandom_range(0, 7));
            #1;
            tests++;
            if (bus.mdu_ready !== (buffer.size() == 0) ||
                bus.hazard1 !== busy[bus.read_addr1] || bus.hazard2 !== busy[bus.read_addr2]) begin
                fails++;
                $display("FAIL rand_comb[%0d]: got ready=%b hz1=%b hz2=%b, need %b/%b/%b", cyc,
                         bus.mdu_ready, bus.hazard1, bus.hazard2,
                         buffer.size() == 0, busy[bus.read_addr1], busy[bus.read_addr2]);
            end
            // Candidates in priority order; the head wins, leftover MDU results park.
            had_buf = buffer.size() != 0;
            cands.delete();
            if (bus.pipe_valid && bus.pipe_addr != 0)
                cands.push_back('{bus.pipe_addr, bus.pipe_data, 1'b0});
            foreach (buffer[i]) cands.push_back(buffer[i]);
            if (!had_buf && bus.mdu_valid && bus.mdu_addr != 0)
                cands.push_back('{bus.mdu_addr, bus.mdu_data, 1'b1});
            exp_en = cands.size() != 0;
            if (exp_en) begin
                win = cands.pop_front();
                exp_addr = win.a;
                exp_data = win.d;
                if (win.from_mdu) busy[win.a] = 1'b0;
            end
            buffer.delete();
            foreach (cands[i]) if (cands[i].from_mdu) buffer.push_back(cands[i]);
            buf_stayed = had_buf && buffer.size() != 0;
            waits = buf_stayed ? waits + 1 : 0;
            hold = buf_stayed && waits == LIMIT;
            if (bus.issue_valid && bus.issue_addr != 0) busy[bus.issue_addr] = 1'b1;
            step();
            tests++;
            if (bus.write_en !== exp_en || bus.write_addr !== exp_addr ||
                bus.write_data !== exp_data || bus.pipe_hold !== hold) begin
                fails++;
                $display("FAIL rand_write[%0d]: got en=%b addr=%0d data=%h hold=%b, need %b/%0d/%h/%b",
                         cyc, bus.write_en, bus.write_addr, bus.write_data, bus.pipe_hold,
                         exp_en, exp_addr, exp_data, hold);
            end
        end
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        idle();
        test_reset();
        #10;
        rst = 1'b0;
        step();
        test_reset_mid();
        test_lone_pipe();
        test_collision();
        test_starvation();
        test_x0_discard();
        test_scoreboard_race();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
